// File: rtl/prince_inv_sbox_cms_if.sv
// Handshake and share bus for the masked PRINCE inverse S-box.
// The randomness bus is named rnd because rand is a reserved word.
interface prince_inv_sbox_cms_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_s0;
    logic [3:0]  in_s1;
    logic [31:0] rnd;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_s0;
    logic [3:0]  out_s1;

    // Upstream/downstream view: drives inputs and accepts outputs.
    modport master (
        output in_valid, in_s0, in_s1, rnd, out_ready,
        input  in_ready, out_valid, out_s0, out_s1
    );

    // Block view.
    modport slave (
        input  in_valid, in_s0, in_s1, rnd, out_ready,
        output in_ready, out_valid, out_s0, out_s1
    );
endinterface

// File: rtl/prince_inv_sbox_cms.sv
// Two-share first-order CMS PRINCE inverse S-box.
// Stage 1 expands each output bit into eight non-complete shares with ring
// refresh and registers them; stage 2 compresses back to two shares.
// Share j reads x_{j2}, y_{j1}, z_{j0}, w_{j2^j1^j0}; rnd[8i+j] is m_j of bit i.
module prince_inv_sbox_cms (
    input logic                   clk,
    input logic                   rst_n,
    prince_inv_sbox_cms_if.slave  bus
);

    // Unmasked inverse S-box, entry v at bits [4v+3:4v].
    localparam logic [63:0] SINV_TBL = 64'h1CE5_046A_98DF_237B;

    // ANF coefficients of each output bit (Moebius transform of the table).
    // Bit 16*b+m is the coefficient of monomial m (bit0=x, 1=y, 2=z, 3=w).
    function automatic logic [63:0] anf_all();
        logic [63:0] a;
        logic [15:0] t;
        a = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            t = '0;
            for (int unsigned v = 0; v < 16; v++) t[v] = SINV_TBL[4*v+b];
            for (int unsigned k = 0; k < 4; k++)
                for (int unsigned v = 0; v < 16; v++)
                    if (v[k]) t[v] = t[v] ^ t[v ^ (32'd1 << k)];
            a[16*b +: 16] = t;
        end
        return a;
    endfunction

    localparam logic [63:0] ANF = anf_all();

    // Lowest share index whose domain selection covers the expanded term
    // with variable set m and per-variable share choice c.
    function automatic logic [2:0] home_share(input logic [3:0] m, input logic [3:0] c);
        logic [2:0] h;
        logic [2:0] jj;
        h = 3'd0;
        for (int unsigned n = 0; n < 8; n++) begin
            jj = 3'(7 - n);
            if (!(m[0] && (jj[2] != c[0])) &&
                !(m[1] && (jj[1] != c[1])) &&
                !(m[2] && (jj[0] != c[2])) &&
                !(m[3] && ((^jj) != c[3])))
                h = jj;
        end
        return h;
    endfunction

    logic [31:0] f;
    logic [31:0] r;
    logic [31:0] s1_r;
    logic        s1_valid;
    logic        o_valid;
    logic [3:0]  o_s0;
    logic [3:0]  o_s1;
    logic [3:0]  c0;
    logic [3:0]  c1;
    logic        adv1;
    logic        adv2;

    assign adv2          = !o_valid | bus.out_ready;
    assign adv1          = !s1_valid | adv2;
    assign bus.in_ready  = adv1;
    assign bus.out_valid = o_valid;
    assign bus.out_s0    = o_s0;
    assign bus.out_s1    = o_s1;

    // Expansion: every share combination of every ANF monomial is routed to
    // its home share, so each f[8i+j] only sees the shares allowed for j.
    always_comb begin
        logic [3:0] m;
        logic [3:0] c;
        logic       term;
        logic [2:0] h;
        f    = '0;
        m    = '0;
        c    = '0;
        term = 1'b0;
        h    = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            f[8*i] = ANF[16*i];
            for (int unsigned mi = 1; mi < 16; mi++) begin
                if (ANF[16*i+mi]) begin
                    for (int unsigned ci = 0; ci < 16; ci++) begin
                        m = 4'(mi);
                        c = 4'(ci);
                        if ((c & ~m) == 4'd0) begin
                            term = 1'b1;
                            for (int unsigned k = 0; k < 4; k++)
                                if (m[k]) term = term & (c[k] ? bus.in_s1[k] : bus.in_s0[k]);
                            h = home_share(m, c);
                            f[8*i + 32'(h)] = f[8*i + 32'(h)] ^ term;
                        end
                    end
                end
            end
        end
    end

    // Ring refresh: each mask enters two neighbouring shares and cancels.
    always_comb begin
        r = '0;
        for (int unsigned i = 0; i < 4; i++)
            for (int unsigned j = 0; j < 8; j++)
                r[8*i+j] = f[8*i+j] ^ bus.rnd[8*i+j] ^ bus.rnd[8*i + ((j+1) % 8)];
    end

    // Compression of registered shares: 0..3 to share 0, 4..7 to share 1.
    always_comb begin
        c0 = '0;
        c1 = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            c0[i] = ^s1_r[8*i +: 4];
            c1[i] = ^s1_r[8*i+4 +: 4];
        end
    end

    // Stage 1 register: captures refreshed shares on an accepted input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r     <= '0;
            s1_valid <= 1'b0;
        end else if (adv1) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) s1_r <= r;
        end
    end

    // Stage 2 register: captures compressed shares when stage 1 moves on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_s0    <= '0;
            o_s1    <= '0;
            o_valid <= 1'b0;
        end else if (adv2) begin
            o_valid <= s1_valid;
            if (s1_valid) begin
                o_s0 <= c0;
                o_s1 <= c1;
            end
        end
    end

endmodule

// File: tb/tb_prince_inv_sbox_cms.sv
// Scoreboard bench for the masked PRINCE inverse S-box.
module tb_prince_inv_sbox_cms;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prince_inv_sbox_cms_if bus();

    prince_inv_sbox_cms dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [3:0] sinv [16] = '{4'hB, 4'h7, 4'h3, 4'h2, 4'hF, 4'hD, 4'h8, 4'h9,
                              4'hA, 4'h6, 4'h4, 4'h0, 4'h5, 4'hE, 4'hC, 4'h1};

    logic [3:0] sb[$];
    logic [3:0] s0_log[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops an expected value on every output transfer.
    initial begin
        logic [3:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 32'(bus.out_s0 ^ bus.out_s1), 32'hFFFF);
                end else begin
                    e = sb.pop_front();
                    chk("recombined", 32'(bus.out_s0 ^ bus.out_s1), 32'(e));
                    s0_log.push_back(bus.out_s0);
                end
            end
        end
    end

    // Drive one nibble with a mask; expected value queued at acceptance.
    task automatic push(input logic [3:0] v, input logic [3:0] mask);
        int unsigned w;
        w = 0;
        bus.in_valid = 1'b1;
        bus.in_s0    = v ^ mask;
        bus.in_s1    = mask;
        bus.rnd      = $urandom;
        @(negedge clk);
        while (!bus.in_ready && w < 20) begin
            w++;
            @(negedge clk);
        end
        if (!bus.in_ready) chk("accept_timeout", 32'(bus.in_ready), 32'd1);
        else sb.push_back(sinv[v]);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.rnd      = $urandom;
    endtask

    task automatic drain();
        int unsigned w;
        w = 0;
        while (sb.size() != 0 && w < 50) begin
            w++;
            @(negedge clk);
        end
        if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] a0;
        logic [3:0] a1;
        logic       diff;
        int unsigned w;

        bus.in_valid  = 1'b0;
        bus.in_s0     = '0;
        bus.in_s1     = '0;
        bus.rnd       = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_s0", 32'(bus.out_s0), 32'd0);
        chk("rst_out_s1", 32'(bus.out_s1), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Exhaustive values, four masks each, full throughput
        for (int unsigned v = 0; v < 16; v++)
            for (int unsigned k = 0; k < 4; k++)
                push(4'(v), 4'($urandom));
        drain();

        // Randomness independence: v=4, fixed mask, rand swept
        s0_log.delete();
        for (int unsigned n = 0; n < 16; n++) push(4'h4, 4'h9);
        drain();
        diff = 1'b0;
        foreach (s0_log[n]) if (s0_log[n] != s0_log[0]) diff = 1'b1;
        chk("s0_varies_with_rand", 32'(diff), 32'd1);

        // Backpressure: 1, 2 fill both stages, 3 waits for out_ready
        bus.out_ready = 1'b0;
        push(4'h1, 4'h6);
        push(4'h2, 4'hB);
        bus.in_valid = 1'b1;
        bus.in_s0    = 4'h3 ^ 4'h5;
        bus.in_s1    = 4'h5;
        bus.rnd      = $urandom;
        @(negedge clk);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        chk("full_out_valid", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        chk("full_in_ready_hold", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("pop_push_in_ready", 32'(bus.in_ready), 32'd1);
        sb.push_back(sinv[3]);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        drain();

        // Stall stability while rand toggles
        bus.out_ready = 1'b0;
        push(4'hC, 4'h3);
        w = 0;
        while (!bus.out_valid && w < 10) begin
            w++;
            @(negedge clk);
        end
        if (!bus.out_valid) chk("stall_valid_timeout", 32'(bus.out_valid), 32'd1);
        a0 = bus.out_s0;
        a1 = bus.out_s1;
        for (int unsigned n = 0; n < 5; n++) begin
            @(posedge clk);
            #1;
            bus.rnd = $urandom;
            @(negedge clk);
            chk("stall_s0", 32'(bus.out_s0), 32'(a0));
            chk("stall_s1", 32'(bus.out_s1), 32'(a1));
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        drain();

        // Reset mid-flight with both stages full
        bus.out_ready = 1'b0;
        push(4'h5, 4'h2);
        push(4'h6, 4'h8);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_out_s0", 32'(bus.out_s0), 32'd0);
        chk("midrst_out_s1", 32'(bus.out_s1), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        push(4'hA, 4'hD);
        @(negedge clk);
        chk("lat_after_k", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk("lat_after_k1", 32'(bus.out_valid), 32'd1);
        drain();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prince_inv_sbox_cms.md
# prince_inv_sbox_cms

Two-share, first-order Consolidated Masking Scheme (CMS) implementation of the PRINCE inverse S-box for the decryption datapath. It accepts a masked 4-bit nibble as two Boolean shares and produces the masked inverse S-box output as two shares. The block has a two-stage register pipeline: expansion to eight non-complete shares with ring refresh, then compression back to two shares. A valid/ready handshake lets it sit between the inverse-ShiftRows/key-add registers and the inverse M-layer with backpressure.

## Interface
- No parameters; widths are fixed by the PRINCE S-box.
- clk  in  1  single clock; all registers update on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input nibble shares and rand are valid
- in_ready  out  1  block accepts input this cycle (combinational)
- in_s0  in  4  input share 0; bit0=x, bit1=y, bit2=z, bit3=w
- in_s1  in  4  input share 1, same bit mapping
- rand  in  32  fresh randomness; bits [8i+7:8i] are m0..m7 for output bit i
- out_valid  out  1  output shares valid
- out_ready  in  1  downstream accepts output
- out_s0  out  4  output share 0
- out_s1  out  4  output share 1

## Operation
- Unmasked function: S^-1 = {B,7,3,2,F,D,8,9,A,6,4,0,5,E,C,1} for inputs 0..F. Required invariant: out_s0 ^ out_s1 = S^-1(in_s0 ^ in_s1).
- Every output bit has algebraic degree 3 in (w,z,y,x).
- **Stage 1, expansion (combinational):** for each output bit i, compute eight component shares f_i,j, j = 0..7, with j = (j2 j1 j0).
  - Share j reads only x_{j2}, y_{j1}, z_{j0} and w_{j2^j1^j0}, where the subscript is the share index 0 or 1. This makes the scheme non-complete.
  - Expand every ANF monomial of S^-1 bit i over all share combinations.
  - Assign each expanded term to the lowest-index j whose share-domain selection contains it.
  - The constant term goes to j=0.
  - Each degree-3 term lands in exactly one j. Degree-1 and degree-2 terms land in the lowest matching j.
- **Ring refresh:** r_i,j = f_i,j ^ m_j ^ m_((j+1) mod 8), using the rand byte for bit i. The refresh cancels in the XOR over j. Results are captured in 32 stage-1 registers plus s1_valid.
- **Stage 2, compression:** out_s0[i] = XOR of r_i,0..r_i,3 and out_s1[i] = XOR of r_i,4..r_i,7. Results are registered together with out_valid.
- No combinational path from in_s* to out_s*. Glitch-sensitive logic is confined to stage 1, and its output is always registered before compression.
- **Handshake:**
  - adv2 = !out_valid | out_ready
  - adv1 = !s1_valid | adv2
  - in_ready = adv1
  - Stage-1 registers load in_s*/rand-derived values and s1_valid <= in_valid when adv1.
  - Stage-2 registers load compressed values and out_valid <= s1_valid when adv2.
  - Data registers capture only on an accepted transfer (valid & advance); otherwise they hold.
- rand is consumed only on cycles where in_valid & in_ready. Upstream must supply fresh rand on every accepted transfer.
- A stalled stage holds both its data and its valid bit. out_s* stays stable while out_valid & !out_ready.

## Timing
- Latency is 2 cycles: input accepted at edge k gives out_valid high after edge k+1, and the result is visible during cycle k+1..k+2.
- Throughput is 1 nibble per cycle when out_ready is held high.
- With out_ready low, at most 2 nibbles are buffered. in_ready goes low once both stages are full.
- Simultaneous events:
  - Pop and push in the same cycle while full: both complete, with no bubble and no loss.
  - out_ready rising while stage 1 is full: both stages shift in that cycle.
- Reset values:
  - All share registers are 0, s1_valid = 0, out_valid = 0.
  - in_ready = 1 during and after reset.
  - out_s0 = out_s1 = 0.
- Reset asserted mid-operation discards in-flight nibbles immediately (asynchronous). The first accept after release behaves as from empty.

## Test plan
- Exhaustive correctness: all 16 values v, each with 4 random masks, in_s0 = v^mask, in_s1 = mask, out_ready=1. Required: (out_s0^out_s1) equals the S^-1 table entry, e.g. v=0 gives B and v=F gives 1, 2 cycles after acceptance.
- Randomness independence: fix v=0x4 and sweep rand. The recombined output is always F while out_s0 varies. Share 0 must take more than one value across rand.
- Backpressure: push 0x1, 0x2, 0x3 back-to-back with out_ready=0. in_ready drops after 2 accepts. Then raise out_ready: outputs recombine in order to 7, 3, 2, with no duplication or loss.
- Stall stability: hold out_ready=0 for 5 cycles with out_valid=1. out_s0/out_s1 stay unchanged even while rand toggles.
- Reset mid-flight: accept 2 nibbles, pulse rst_n low for 1 cycle. out_valid = 0, in_ready = 1, and all outputs are 0. The next accept of 0xA yields recombined 4 after 2 cycles.
- Non-completeness check: formal or structural probe confirming each stage-1 register cone depends on exactly one share of each of x, y, z, w.
